// File: rtl/dram_line_arbiter.sv
// Line-granular DRAM port arbiter shared by the instruction cache (refill)
// and the data cache (refill / write-back), with round-robin and watchdog.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   ic_req_i, ic_add_i           icache line read request and byte address
//   ic_gnt_o, ic_valid_o         grant pulse, response pulse
//   ic_data_o                    returned line
//   dc_req_i, dc_we_i            dcache request, 1 = write-back
//   dc_add_i, dc_data_i          dcache byte address, write-back line
//   dc_gnt_o, dc_valid_o         grant pulse, response pulse
//   dc_data_o                    returned line (0 for writes)
//   mem_add_o, mem_data_o        DRAM line address and write data
//   mem_re_o, mem_we_o           DRAM enables, held for the whole access
//   mem_rvalid_i, mem_wvalid_i   DRAM completion strobes
//   mem_data_i                   DRAM read data
//   busy_o                       transaction in flight
//   timeout_o                    sticky watchdog flag
module dram_line_arbiter #(
    parameter int ByteOffsetBits = 5,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int LINE_SIZE = 8 * (2 ** ByteOffsetBits)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ic_req_i,
    input  logic [31:0]          ic_add_i,
    output logic                 ic_gnt_o,
    output logic                 ic_valid_o,
    output logic [LINE_SIZE-1:0] ic_data_o,
    input  logic                 dc_req_i,
    input  logic                 dc_we_i,
    input  logic [31:0]          dc_add_i,
    input  logic [LINE_SIZE-1:0] dc_data_i,
    output logic                 dc_gnt_o,
    output logic                 dc_valid_o,
    output logic [LINE_SIZE-1:0] dc_data_o,
    output logic [31:0]          mem_add_o,
    output logic                 mem_we_o,
    output logic [LINE_SIZE-1:0] mem_data_o,
    input  logic                 mem_wvalid_i,
    output logic                 mem_re_o,
    input  logic                 mem_rvalid_i,
    input  logic [LINE_SIZE-1:0] mem_data_i,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] AddrMask = ~((32'd1 << ByteOffsetBits) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t               r_state,    w_state;
    logic                 r_last_dc,  w_last_dc;
    logic                 r_own_dc,   w_own_dc;
    logic [31:0]          r_add,      w_add;
    logic [LINE_SIZE-1:0] r_wdata,    w_wdata;
    logic [CntW-1:0]      r_cnt,      w_cnt;
    logic                 r_ic_gnt,   w_ic_gnt;
    logic                 r_dc_gnt,   w_dc_gnt;
    logic                 r_ic_valid, w_ic_valid;
    logic                 r_dc_valid, w_dc_valid;
    logic [LINE_SIZE-1:0] r_ic_data,  w_ic_data;
    logic [LINE_SIZE-1:0] r_dc_data,  w_dc_data;
    logic                 r_re,       w_re;
    logic                 r_we,       w_we;
    logic                 r_busy,     w_busy;
    logic                 r_timeout,  w_timeout;

    logic w_pick_dc;
    logic w_pick_ic;
    logic w_done;
    logic w_expire;

    // r_last_dc remembers who was served last; on a tie the other side wins.
    assign w_pick_dc = dc_req_i & (~ic_req_i | ~r_last_dc);
    assign w_pick_ic = ic_req_i & ~w_pick_dc;

    // Only the strobe matching the active direction counts.
    assign w_done   = (r_state == S_READ)  ? mem_rvalid_i :
                      (r_state == S_WRITE) ? mem_wvalid_i : 1'b0;
    assign w_expire = (r_cnt == CntLast);

    always_comb begin
        w_state    = r_state;
        w_last_dc  = r_last_dc;
        w_own_dc   = r_own_dc;
        w_add      = r_add;
        w_wdata    = r_wdata;
        w_cnt      = r_cnt;
        w_re       = r_re;
        w_we       = r_we;
        w_timeout  = r_timeout;
        w_ic_gnt   = 1'b0;
        w_dc_gnt   = 1'b0;
        w_ic_valid = 1'b0;
        w_dc_valid = 1'b0;
        w_ic_data  = '0;
        w_dc_data  = '0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (w_pick_dc) begin
                    w_own_dc  = 1'b1;
                    w_last_dc = 1'b1;
                    w_dc_gnt  = 1'b1;
                    w_add     = dc_add_i & AddrMask;
                    w_wdata   = dc_we_i ? dc_data_i : '0;
                    w_state   = dc_we_i ? S_WRITE : S_READ;
                    w_we      = dc_we_i;
                    w_re      = ~dc_we_i;
                end else if (w_pick_ic) begin
                    w_own_dc  = 1'b0;
                    w_last_dc = 1'b0;
                    w_ic_gnt  = 1'b1;
                    w_add     = ic_add_i & AddrMask;
                    w_wdata   = '0;
                    w_state   = S_READ;
                    w_we      = 1'b0;
                    w_re      = 1'b1;
                end
            end
            S_READ, S_WRITE: begin
                if (w_done || w_expire) begin
                    w_state    = S_RESP;
                    w_re       = 1'b0;
                    w_we       = 1'b0;
                    w_ic_valid = ~r_own_dc;
                    w_dc_valid = r_own_dc;
                    // A real completion beats an expiring watchdog.
                    if (w_done && r_state == S_READ) begin
                        if (r_own_dc) begin
                            w_dc_data = mem_data_i;
                        end else begin
                            w_ic_data = mem_data_i;
                        end
                    end
                    if (!w_done) begin
                        w_timeout = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + CntW'(1);
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_re    = 1'b0;
                w_we    = 1'b0;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_last_dc  <= 1'b0;
            r_own_dc   <= 1'b0;
            r_add      <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_ic_gnt   <= 1'b0;
            r_dc_gnt   <= 1'b0;
            r_ic_valid <= 1'b0;
            r_dc_valid <= 1'b0;
            r_ic_data  <= '0;
            r_dc_data  <= '0;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_last_dc  <= w_last_dc;
            r_own_dc   <= w_own_dc;
            r_add      <= w_add;
            r_wdata    <= w_wdata;
            r_cnt      <= w_cnt;
            r_ic_gnt   <= w_ic_gnt;
            r_dc_gnt   <= w_dc_gnt;
            r_ic_valid <= w_ic_valid;
            r_dc_valid <= w_dc_valid;
            r_ic_data  <= w_ic_data;
            r_dc_data  <= w_dc_data;
            r_re       <= w_re;
            r_we       <= w_we;
            r_busy     <= w_busy;
            r_timeout  <= w_timeout;
        end
    end

    assign ic_gnt_o   = r_ic_gnt;
    assign ic_valid_o = r_ic_valid;
    assign ic_data_o  = r_ic_data;
    assign dc_gnt_o   = r_dc_gnt;
    assign dc_valid_o = r_dc_valid;
    assign dc_data_o  = r_dc_data;
    assign mem_add_o  = r_add;
    assign mem_data_o = r_wdata;
    assign mem_re_o   = r_re;
    assign mem_we_o   = r_we;
    assign busy_o     = r_busy;
    assign timeout_o  = r_timeout;

endmodule
